// File: rtl/cd_pkg.sv
// Shared constants and FSM encoding for the SPI-to-CSR bridge.
package cd_pkg;

    localparam int unsigned SPI_HDR_WR_BIT = 7;
    localparam int unsigned CSR_ADDR_W     = 5;
    localparam int unsigned CSR_DATA_W     = 8;
    localparam int unsigned BIT_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_e;

endpackage

// File: rtl/cd_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulse detection on the last stage.
module cd_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    // Shift chain toward the last stage; delayed copy feeds the edge detector.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = async_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        dly_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer registers, reset to the idle level of the pin.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE_VAL}};
            dly_q  <= IDLE_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_c = sync_o & ~dly_q;
    assign fall_c = ~sync_o & dly_q;

endmodule

// File: rtl/cd_spi_csr_bridge.sv
// SPI mode-0 slave acting as initiator on the CSR bus: header byte picks
// read/write and address, each following byte is one CSR access.
module cd_spi_csr_bridge
    import cd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        MISO_IDLE   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sck,
    input  logic                  spi_nss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [CSR_ADDR_W-1:0] csr_address,
    output logic                  csr_read,
    input  logic [CSR_DATA_W-1:0] csr_readdata,
    output logic                  csr_write,
    output logic [CSR_DATA_W-1:0] csr_writedata,
    output logic                  int_flag_update
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(CSR_DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] FIRST_BIT = '0;

    logic sck_level_unused;
    logic sck_rise_c;
    logic sck_fall_c;
    logic nss_s;
    logic nss_rise_c;
    logic nss_fall_c;
    logic mosi_s;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    cd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (spi_sck),
        .sync_o  (sck_level_unused),
        .rise_c  (sck_rise_c),
        .fall_c  (sck_fall_c)
    );

    cd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_nss (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (spi_nss),
        .sync_o  (nss_s),
        .rise_c  (nss_rise_c),
        .fall_c  (nss_fall_c)
    );

    cd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (spi_mosi),
        .sync_o  (mosi_s),
        .rise_c  (mosi_rise_unused),
        .fall_c  (mosi_fall_unused)
    );

    state_e                  state_q,         state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q,       bit_cnt_d;
    logic [CSR_DATA_W-2:0]   rx_q,            rx_d;
    logic [CSR_DATA_W-1:0]   tx_q,            tx_d;
    logic                    load_pend_q,     load_pend_d;
    logic [CSR_ADDR_W-1:0]   csr_address_q,   csr_address_d;
    logic                    csr_read_q,      csr_read_d;
    logic                    csr_write_q,     csr_write_d;
    logic [CSR_DATA_W-1:0]   csr_writedata_q, csr_writedata_d;
    logic                    int_flag_q,      int_flag_d;
    logic                    miso_q,          miso_d;
    logic                    miso_oe_q,       miso_oe_d;
    logic [CSR_DATA_W-1:0]   rx_next;
    logic                    last_bit;

    // Next-state, shift and strobe logic.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        rx_d            = rx_q;
        tx_d            = tx_q;
        load_pend_d     = 1'b0;
        csr_address_d   = csr_address_q;
        csr_read_d      = 1'b0;
        csr_write_d     = 1'b0;
        csr_writedata_d = csr_writedata_q;
        int_flag_d      = 1'b0;
        miso_d          = miso_q;
        miso_oe_d       = ~nss_s;
        rx_next         = {rx_q, mosi_s};
        last_bit        = (bit_cnt_q == LAST_BIT);

        unique case (state_q)
            IDLE: begin
                miso_d = MISO_IDLE;
                if (nss_fall_c) begin
                    int_flag_d = 1'b1;
                    bit_cnt_d  = '0;
                    rx_d       = '0;
                    state_d    = HDR;
                end
            end
            HDR: begin
                miso_d = MISO_IDLE;
                if (sck_rise_c) begin
                    rx_d      = rx_next[CSR_DATA_W-2:0];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (last_bit) begin
                        csr_address_d = rx_next[CSR_ADDR_W-1:0];
                        if (rx_next[SPI_HDR_WR_BIT]) begin
                            state_d = WR;
                        end else begin
                            state_d     = RD;
                            load_pend_d = 1'b1;
                        end
                    end
                end
            end
            WR: begin
                miso_d = MISO_IDLE;
                if (sck_rise_c) begin
                    rx_d      = rx_next[CSR_DATA_W-2:0];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (last_bit) begin
                        csr_write_d     = 1'b1;
                        csr_writedata_d = rx_next;
                    end
                end
            end
            RD: begin
                if (sck_rise_c) begin
                    rx_d      = rx_next[CSR_DATA_W-2:0];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == FIRST_BIT) begin
                        csr_read_d = 1'b1;
                    end
                    if (last_bit) begin
                        load_pend_d = 1'b1;
                    end
                end
                if (sck_fall_c) begin
                    miso_d = tx_q[CSR_DATA_W-1];
                    tx_d   = {tx_q[CSR_DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        // Prefetch the byte one clk after its boundary, once csr_address is valid.
        if (load_pend_q) begin
            tx_d = csr_readdata;
        end

        // Deselect abandons any partial byte without issuing a strobe.
        if (nss_rise_c) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            load_pend_d = 1'b0;
            csr_read_d  = 1'b0;
            csr_write_d = 1'b0;
            miso_d      = MISO_IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            rx_q            <= '0;
            tx_q            <= '0;
            load_pend_q     <= 1'b0;
            csr_address_q   <= '0;
            csr_read_q      <= 1'b0;
            csr_write_q     <= 1'b0;
            csr_writedata_q <= '0;
            int_flag_q      <= 1'b0;
            miso_q          <= MISO_IDLE;
            miso_oe_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_q            <= rx_d;
            tx_q            <= tx_d;
            load_pend_q     <= load_pend_d;
            csr_address_q   <= csr_address_d;
            csr_read_q      <= csr_read_d;
            csr_write_q     <= csr_write_d;
            csr_writedata_q <= csr_writedata_d;
            int_flag_q      <= int_flag_d;
            miso_q          <= miso_d;
            miso_oe_q       <= miso_oe_d;
        end
    end

    assign spi_miso        = miso_q;
    assign spi_miso_oe     = miso_oe_q;
    assign csr_address     = csr_address_q;
    assign csr_read        = csr_read_q;
    assign csr_write       = csr_write_q;
    assign csr_writedata   = csr_writedata_q;
    assign int_flag_update = int_flag_q;

endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// Directed bench for cd_spi_csr_bridge: vector table plus abort/reset sequences.
module tb_cd_spi_csr_bridge;
    import cd_pkg::*;

    localparam int H = 8;   // SPI half period in clk cycles

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_sck;
    logic       spi_nss;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata;
    logic       csr_write;
    logic [7:0] csr_writedata;
    logic       int_flag_update;

    always #5 clk = ~clk;

    cd_spi_csr_bridge #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .spi_sck         (spi_sck),
        .spi_nss         (spi_nss),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso),
        .spi_miso_oe     (spi_miso_oe),
        .csr_address     (csr_address),
        .csr_read        (csr_read),
        .csr_readdata    (csr_readdata),
        .csr_write       (csr_write),
        .csr_writedata   (csr_writedata),
        .int_flag_update (int_flag_update)
    );

    int checks = 0;
    int errors = 0;

    // Register-block model: a small FIFO whose read pointer advances on csr_read.
    int         rd_ptr = 0;
    int         fifo_base = 0;
    logic [7:0] cur_fifo [3];

    always @(posedge clk) begin
        if (!reset_n) rd_ptr <= rd_ptr;
        else if (csr_read) rd_ptr <= rd_ptr + 1;
    end

    always_comb begin
        int idx;
        idx = rd_ptr - fifo_base;
        csr_readdata = (idx >= 0 && idx < 3) ? cur_fifo[idx] : 8'hEE;
    end

    // Output monitor sampled on the falling clk edge.
    int         rd_cnt = 0;
    int         ifu_cnt = 0;
    int         both_cnt = 0;
    logic [4:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];

    always @(negedge clk) begin
        if (csr_write) begin
            wr_addr_log.push_back(csr_address);
            wr_data_log.push_back(csr_writedata);
        end
        if (csr_read) rd_cnt++;
        if (int_flag_update) ifu_cnt++;
        if (csr_read && csr_write) both_cnt++;
    end

    typedef struct packed {
        logic [7:0]      hdr;
        int              nbytes;
        logic [2:0][7:0] data;        // write data, or FIFO contents for reads
        logic [4:0]      exp_addr;
        int              exp_writes;
        int              exp_reads;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master clocks n bits MSB first and samples MISO at each rising SCK.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            cycles(H);
            spi_sck = 1'b1;
            rx = {rx[6:0], spi_miso};
            cycles(H);
            spi_sck = 1'b0;
        end
    endtask

    task automatic set_fifo(input logic [2:0][7:0] d);
        for (int i = 0; i < 3; i++) cur_fifo[i] = d[i];
        fifo_base = rd_ptr;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] rb;
        int wr0, rd0, ifu0;
        set_fifo(v.data);
        wr0  = wr_addr_log.size();
        rd0  = rd_cnt;
        ifu0 = ifu_cnt;
        spi_nss = 1'b0;
        cycles(H);
        chk({tag, " miso_oe_sel"}, spi_miso_oe, 1);
        spi_bits(v.hdr, 8, rb);
        for (int i = 0; i < v.nbytes; i++) begin
            spi_bits((v.exp_writes != 0) ? v.data[i] : 8'h00, 8, rb);
            if (v.exp_reads != 0) chk($sformatf("%s miso_byte%0d", tag, i), rb, v.data[i]);
        end
        cycles(H);
        spi_nss = 1'b1;
        cycles(4 * H);
        chk({tag, " miso_oe_desel"}, spi_miso_oe, 0);
        chk({tag, " int_flag_cnt"}, ifu_cnt - ifu0, 1);
        chk({tag, " write_cnt"}, wr_addr_log.size() - wr0, v.exp_writes);
        for (int i = 0; i < v.exp_writes && wr0 + i < wr_addr_log.size(); i++) begin
            chk($sformatf("%s wr_addr%0d", tag, i), wr_addr_log[wr0 + i], v.exp_addr);
            chk($sformatf("%s wr_data%0d", tag, i), wr_data_log[wr0 + i], v.data[i]);
        end
        chk({tag, " read_cnt"}, rd_cnt - rd0, v.exp_reads);
        chk({tag, " fifo_ptr"}, rd_ptr - fifo_base, v.exp_reads);
        chk({tag, " csr_address"}, csr_address, v.exp_addr);
    endtask

    initial begin
        logic [7:0] rb;
        int wr0, rd0, ifu0;
        vec_t v_after_abort;

        vecs[0] = '{hdr: 8'h82, nbytes: 1, data: 24'h000055, exp_addr: 5'h02, exp_writes: 1, exp_reads: 0};
        vecs[1] = '{hdr: 8'h95, nbytes: 3, data: 24'h332211, exp_addr: 5'h15, exp_writes: 3, exp_reads: 0};
        vecs[2] = '{hdr: 8'h00, nbytes: 1, data: 24'h00000E, exp_addr: 5'h00, exp_writes: 0, exp_reads: 1};
        vecs[3] = '{hdr: 8'h14, nbytes: 2, data: 24'hC3B2A1, exp_addr: 5'h14, exp_writes: 0, exp_reads: 2};
        vecs[4] = '{hdr: 8'hE9, nbytes: 2, data: 24'h000FF0, exp_addr: 5'h09, exp_writes: 2, exp_reads: 0};
        vecs[5] = '{hdr: 8'h7F, nbytes: 3, data: 24'h81C35A, exp_addr: 5'h1F, exp_writes: 0, exp_reads: 3};
        v_after_abort = '{hdr: 8'h89, nbytes: 1, data: 24'h000003, exp_addr: 5'h09, exp_writes: 1, exp_reads: 0};

        for (int i = 0; i < 3; i++) cur_fifo[i] = 8'h00;
        reset_n  = 1'b0;
        spi_sck  = 1'b0;
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
        cycles(3);

        chk("rst csr_read", csr_read, 0);
        chk("rst csr_write", csr_write, 0);
        chk("rst csr_address", csr_address, 0);
        chk("rst csr_writedata", csr_writedata, 0);
        chk("rst int_flag", int_flag_update, 0);
        chk("rst miso", spi_miso, 0);
        chk("rst miso_oe", spi_miso_oe, 0);

        reset_n = 1'b1;
        cycles(5);
        chk("idle no int_flag", ifu_cnt, 0);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Deselect after 5 data bits: no write for the partial byte.
        wr0  = wr_addr_log.size();
        rd0  = rd_cnt;
        ifu0 = ifu_cnt;
        spi_nss = 1'b0;
        cycles(H);
        spi_bits(8'h82, 8, rb);
        spi_bits(8'hFF, 5, rb);
        cycles(H);
        spi_nss = 1'b1;
        cycles(4 * H);
        chk("abort write_cnt", wr_addr_log.size() - wr0, 0);
        chk("abort read_cnt", rd_cnt - rd0, 0);
        chk("abort int_flag_cnt", ifu_cnt - ifu0, 1);
        chk("abort addr_hold", csr_address, 5'h02);
        run_vec(v_after_abort, "post_abort");

        // Reset in the middle of the second byte of a read burst.
        set_fifo(24'hC3B2A1);
        spi_nss = 1'b0;
        cycles(H);
        spi_bits(8'h14, 8, rb);
        spi_bits(8'h00, 8, rb);
        chk("rstmid first_byte", rb, 8'hA1);
        spi_bits(8'h00, 3, rb);
        reset_n = 1'b0;
        cycles(2);
        chk("rstmid csr_read", csr_read, 0);
        chk("rstmid csr_write", csr_write, 0);
        chk("rstmid csr_address", csr_address, 0);
        chk("rstmid csr_writedata", csr_writedata, 0);
        chk("rstmid int_flag", int_flag_update, 0);
        chk("rstmid miso", spi_miso, 0);
        chk("rstmid miso_oe", spi_miso_oe, 0);
        chk("rstmid state", dut.state_q, IDLE);
        spi_sck = 1'b0;
        spi_nss = 1'b1;
        cycles(2);
        ifu0 = ifu_cnt;
        wr0  = wr_addr_log.size();
        reset_n = 1'b1;
        cycles(4 * H);
        chk("rstmid quiet int_flag", ifu_cnt - ifu0, 0);
        chk("rstmid quiet write", wr_addr_log.size() - wr0, 0);
        run_vec(vecs[3], "post_reset");

        chk("rd_wr_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
